// File: rtl/window_sum_3_if.sv
// Handshake bundle for the three-tap window summer: upstream sample
// port, flush control, downstream result port and status flags.
interface window_sum_3_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             sat;
  logic             primed;

  modport master (
    output in_valid, in, flush, out_ready,
    input  in_ready, out_valid, out, sat, primed
  );

  modport slave (
    input  in_valid, in, flush, out_ready,
    output in_ready, out_valid, out, sat, primed
  );
endinterface

// File: rtl/window_sum_3.sv
// Saturating sum of the newest sample and the two before it, with a
// fill tracker so no result is produced until two older samples exist.
//
// state | meaning
// EMPTY | no samples held
// ONE   | t0 valid
// TWO   | t0, t1 valid; next accept produces a result
// FULL  | t0..t2 valid (primed)
module window_sum_3 #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  window_sum_3_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] t0_q, t0_d, t1_q, t1_d, t2_q, t2_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic                    in_ready;
  logic                    accept;
  logic                    produce;
  logic signed [WIDTH+1:0] sum;

  localparam logic signed [WIDTH+1:0] MAX_S = $signed({3'b000, {(WIDTH-1){1'b1}}});
  localparam logic signed [WIDTH+1:0] MIN_S = $signed({3'b111, {(WIDTH-1){1'b0}}});

  // Output slot may be refilled in the same cycle it is drained.
  assign in_ready = rst && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign produce  = accept && ((state_q == TWO) || (state_q == FULL));
  assign sum      = $signed({{2{bus.in[WIDTH-1]}}, bus.in})
                  + $signed({{2{t0_q[WIDTH-1]}}, t0_q})
                  + $signed({{2{t1_q[WIDTH-1]}}, t1_q});

  always_comb begin
    state_d     = state_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    out_d       = out_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    if (bus.flush) begin
      state_d = EMPTY;
      t0_d    = '0;
      t1_d    = '0;
      t2_d    = '0;
    end else if (accept) begin
      t0_d = bus.in;
      t1_d = t0_q;
      t2_d = t1_q;
      case (state_q)
        EMPTY:   state_d = ONE;
        ONE:     state_d = TWO;
        default: state_d = FULL;
      endcase
    end

    if (produce) begin
      out_valid_d = 1'b1;
      if (sum > MAX_S) begin
        out_d = MAX_S[WIDTH-1:0];
        sat_d = 1'b1;
      end else if (sum < MIN_S) begin
        out_d = MIN_S[WIDTH-1:0];
        sat_d = 1'b1;
      end else begin
        out_d = sum[WIDTH-1:0];
        sat_d = 1'b0;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      t0_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.sat       = sat_q;
  assign bus.out_valid = out_valid_q;
  assign bus.primed    = (state_q == FULL);
endmodule
